// File: rtl/mem_responder.sv
// Word-read memory responder: in-order, fixed-latency responses with a bounded
// outstanding queue and response backpressure, plus a backdoor write port for loaders.
module mem_responder #(
  parameter logic [31:0] BASE            = 32'h8000_0000,
  parameter int          WORDS           = 1024,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic [31:0] mem_req_addr,
  output logic        mem_resp_valid,
  input  logic        mem_resp_ready,
  output logic [31:0] mem_resp_data,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int AW = $clog2(LATENCY + 1);
  localparam logic [31:0] SPAN = 32'(4 * WORDS);

  logic [31:0] mem [WORDS];

  logic [31:0] req_off, wr_off;
  logic        req_in_range, wr_in_range;
  logic [IW-1:0] req_idx, wr_idx;
  logic [31:0] read_word;

  logic [31:0]   word_q [MAX_OUTSTANDING];
  logic [AW-1:0] age_q  [MAX_OUTSTANDING];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          push, pop;

  // Unsigned wrap makes addresses below BASE land far above SPAN, so one compare covers both ends.
  assign req_off      = mem_req_addr - BASE;
  assign req_in_range = req_off < SPAN;
  assign req_idx      = req_off[IW+1:2];
  assign wr_off       = wr_addr - BASE;
  assign wr_in_range  = wr_off < SPAN;
  assign wr_idx       = wr_off[IW+1:2];

  assign read_word = req_in_range ? mem[req_idx] : 32'h0;

  assign mem_req_ready  = count_q < CW'(MAX_OUTSTANDING);
  assign mem_resp_valid = (count_q != '0) && (age_q[head_q] == AW'(LATENCY));
  assign mem_resp_data  = mem_resp_valid ? word_q[head_q] : 32'h0;

  assign push = mem_req_valid & mem_req_ready;
  assign pop  = mem_resp_valid & mem_resp_ready;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= next_ptr(tail_q);
      if (pop)  head_q <= next_ptr(head_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Every slot ages each cycle; stale slots are harmless because a push reloads age.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (rst) begin
        age_q[i] <= '0;
      end else if (push && tail_q == PW'(i)) begin
        age_q[i] <= AW'(1);
      end else if (age_q[i] < AW'(LATENCY)) begin
        age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  // The word is captured at request fire, so later backdoor writes never alter it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (push && tail_q == PW'(i)) word_q[i] <= read_word;
    end
  end

endmodule
